// File: rtl/sap_cpu_param.sv
// sap_cpu_param: parametrised SAP-style accumulator CPU (LDA/ADD/SUB/STA/OUT/JMP/JC/JZ/LDI/HLT/NOP).
// Runs on a divided tick enable inside the single clk domain. Single-step and program-load supported.
// Ports: clk/reset_n; run (free-run level), step_req (one T-state when run=0); prog_we/prog_addr/prog_data
//   (RAM load, only while stopped or halted); out_data/out_valid (output register + 1-clk strobe);
//   bus_viewer (registered internal bus for the current T-state); halted (HLT executed).
module sap_cpu_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int CLK_DIV = 800000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              step_req,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] bus_viewer,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int OPR_W = DATA_W - 4;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_OUT = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hE;

  typedef enum logic [2:0] {S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt, mar, mar_nxt;
  logic [DATA_W-1:0]   ir, ir_nxt, a, a_nxt, b, b_nxt;
  logic                c, c_nxt, z, z_nxt;
  logic [DATA_W-1:0]   out_nxt, bus_nxt;
  logic                ov_nxt, ram_we;
  logic [DATA_W-1:0]   ram [DEPTH];
  logic [DATA_W-1:0]   ram_rd, opr_ext, pc_ext, b_eff;
  logic [DATA_W:0]     alu_sum;
  logic [3:0]          opcode;
  logic [OPR_W-1:0]    operand;
  logic [ADDR_W-1:0]   addr;
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [1:0]          rst_sync;
  logic                rst_n;

  // Reset asserts asynchronously, releases two clk edges after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign halted = (state == S_HALT);

  // Divider only counts while free-running; it sits at 0 otherwise so the
  // first free-run tick lands exactly CLK_DIV cycles after run rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  div_cnt <= '0;
    else if (!run || halted)     div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                         div_cnt <= div_cnt + 1'b1;
  end

  assign tick = !halted && (run ? (div_cnt == DIV_LAST) : step_req);

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[OPR_W-1:0];
  assign addr    = operand[ADDR_W-1:0];
  assign opr_ext = {4'b0000, operand};
  assign pc_ext  = {{(DATA_W-ADDR_W){1'b0}}, pc};
  assign ram_rd  = ram[mar];

  // SUB is A + ~B + 1, so carry-out means "no borrow" (A >= B).
  assign b_eff   = (opcode == OP_SUB) ? ~b : b;
  assign alu_sum = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, (opcode == OP_SUB)};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    mar_nxt   = mar;
    ir_nxt    = ir;
    a_nxt     = a;
    b_nxt     = b;
    c_nxt     = c;
    z_nxt     = z;
    out_nxt   = out_data;
    bus_nxt   = bus_viewer;
    ov_nxt    = 1'b0;
    ram_we    = 1'b0;
    if (tick) begin
      bus_nxt = '0;
      case (state)
        S_T1: begin
          mar_nxt   = pc;
          bus_nxt   = pc_ext;
          state_nxt = S_T2;
        end
        S_T2: begin
          ir_nxt    = ram_rd;
          pc_nxt    = pc + 1'b1;
          bus_nxt   = ram_rd;
          state_nxt = S_T3;
        end
        S_T3: begin
          state_nxt = S_T1;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              mar_nxt   = addr;
              bus_nxt   = opr_ext;
              state_nxt = S_T4;
            end
            OP_OUT: begin
              out_nxt = a;
              ov_nxt  = 1'b1;
              bus_nxt = a;
            end
            OP_JMP: begin
              pc_nxt  = addr;
              bus_nxt = opr_ext;
            end
            OP_JC: begin
              if (c) begin
                pc_nxt  = addr;
                bus_nxt = opr_ext;
              end
            end
            OP_JZ: begin
              if (z) begin
                pc_nxt  = addr;
                bus_nxt = opr_ext;
              end
            end
            OP_LDI: begin
              a_nxt   = opr_ext;
              bus_nxt = opr_ext;
            end
            OP_HLT:  state_nxt = S_HALT;
            default: ;
          endcase
        end
        S_T4: begin
          state_nxt = S_T1;
          case (opcode)
            OP_LDA: begin
              a_nxt   = ram_rd;
              bus_nxt = ram_rd;
            end
            OP_ADD, OP_SUB: begin
              b_nxt     = ram_rd;
              bus_nxt   = ram_rd;
              state_nxt = S_T5;
            end
            OP_STA: begin
              ram_we  = 1'b1;
              bus_nxt = a;
            end
            default: ;
          endcase
        end
        S_T5: begin
          a_nxt     = alu_sum[DATA_W-1:0];
          c_nxt     = alu_sum[DATA_W];
          z_nxt     = (alu_sum[DATA_W-1:0] == '0);
          bus_nxt   = alu_sum[DATA_W-1:0];
          state_nxt = S_T1;
        end
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_T1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_T1;
      pc         <= '0;
      mar        <= '0;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      c          <= 1'b0;
      z          <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      bus_viewer <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      mar        <= mar_nxt;
      ir         <= ir_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      c          <= c_nxt;
      z          <= z_nxt;
      out_data   <= out_nxt;
      out_valid  <= ov_nxt;
      bus_viewer <= bus_nxt;
    end
  end

  // RAM is not reset so programs survive reset_n. Loads are only accepted
  // while stopped or halted; STA wins if a single-step STA coincides.
  always_ff @(posedge clk) begin
    if (ram_we)                         ram[mar]       <= a;
    else if (prog_we && (!run || halted)) ram[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_sap_cpu_param.sv
module tb_sap_cpu_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run8 = 1'b0, step8 = 1'b0, we8 = 1'b0;
  logic [3:0]  addr8 = '0;
  logic [7:0]  data8 = '0;
  logic [7:0]  out8, bus8;
  logic        ov8, halt8;
  logic        run12 = 1'b0, step12 = 1'b0, we12 = 1'b0;
  logic [5:0]  addr12 = '0;
  logic [11:0] data12 = '0;
  logic [11:0] out12, bus12;
  logic        ov12, halt12;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int c0;
  logic [31:0] q8[$];
  logic [31:0] q12[$];
  int t8[$];
  int t12[$];

  always #5 clk = ~clk;

  sap_cpu_param #(.DATA_W(8), .ADDR_W(4), .CLK_DIV(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .run(run8), .step_req(step8),
    .prog_we(we8), .prog_addr(addr8), .prog_data(data8),
    .out_data(out8), .out_valid(ov8), .bus_viewer(bus8), .halted(halt8)
  );

  sap_cpu_param #(.DATA_W(12), .ADDR_W(6), .CLK_DIV(3)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .run(run12), .step_req(step12),
    .prog_we(we12), .prog_addr(addr12), .prog_data(data12),
    .out_data(out12), .out_valid(ov12), .bus_viewer(bus12), .halted(halt12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clk cycle; samples on the falling edge and pops the scoreboards.
  task automatic cyc();
    logic [31:0] e;
    @(negedge clk);
    cyc_cnt++;
    if (ov8) begin
      check("sb8_pending", 32'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        check("out8", {24'h0, out8}, e);
      end
      t8.push_back(cyc_cnt);
    end
    if (ov12) begin
      check("sb12_pending", 32'(q12.size() > 0), 1);
      if (q12.size() > 0) begin
        e = q12.pop_front();
        check("out12", {20'h0, out12}, e);
      end
      t12.push_back(cyc_cnt);
    end
  endtask

  task automatic load8(input logic [3:0] a, input logic [7:0] d);
    addr8 = a; data8 = d; we8 = 1'b1;
    cyc();
    we8 = 1'b0;
  endtask

  task automatic load12(input logic [5:0] a, input logic [11:0] d);
    addr12 = a; data12 = d; we12 = 1'b1;
    cyc();
    we12 = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic step_pulse8();
    step8 = 1'b1;
    cyc();
    step8 = 1'b0;
    cyc();
  endtask

  task automatic wait_q8_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !(q8.size() == 0 && halt8); i++) cyc();
    check({tag, "_pending"}, q8.size(), 0);
    check({tag, "_halted"}, {31'h0, halt8}, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) cyc();
    check("rst_out8", {24'h0, out8}, 0);
    check("rst_bus8", {24'h0, bus8}, 0);
    check("rst_ov8", {31'h0, ov8}, 0);
    check("rst_halt8", {31'h0, halt8}, 0);
    check("rst_bus12", {20'h0, bus12}, 0);
    reset_n = 1'b1;
    repeat (3) cyc();

    // Counter loop at CLK_DIV=1: 1,2,3,4 with 11 cycles between OUTs
    load8(4'h0, 8'h14); load8(4'h1, 8'h30); load8(4'h2, 8'h24);
    load8(4'h3, 8'h41); load8(4'h4, 8'h01);
    for (int k = 1; k <= 4; k++) q8.push_back(k);
    t8.delete();
    c0 = cyc_cnt;
    run8 = 1'b1;
    for (int i = 0; i < 100 && q8.size() > 0; i++) cyc();
    run8 = 1'b0;
    check("loop_pending", q8.size(), 0);
    check("loop_pulses", t8.size(), 4);
    if (t8.size() > 0) check("loop_first", t8[0] - c0, 7);
    for (int k = 1; k < t8.size(); k++) check("loop_gap", t8[k] - t8[k-1], 11);

    // ADD overflow then SUB 03-05, flags probed with JC/JZ
    do_reset();
    load8(4'h0, 8'h1D); load8(4'h1, 8'h2E); load8(4'h2, 8'h84); load8(4'h3, 8'hE0);
    load8(4'h4, 8'h96); load8(4'h5, 8'hE0); load8(4'h6, 8'h30); load8(4'h7, 8'h73);
    load8(4'h8, 8'h6F); load8(4'h9, 8'h85); load8(4'hA, 8'h95); load8(4'hB, 8'h30);
    load8(4'hC, 8'hE0); load8(4'hD, 8'hFF); load8(4'hE, 8'h01); load8(4'hF, 8'h05);
    q8.push_back(32'h00);
    q8.push_back(32'hFE);
    run8 = 1'b1;
    wait_q8_halt("arith", 200);
    run8 = 1'b0;

    // LDI 5, SUB F, JZ 5 -> HLT; must freeze afterwards
    do_reset();
    load8(4'h0, 8'h75); load8(4'h1, 8'h6F); load8(4'h2, 8'h95);
    load8(4'h3, 8'h41); load8(4'h4, 8'hF0); load8(4'h5, 8'hE0); load8(4'hF, 8'h05);
    run8 = 1'b1;
    wait_q8_halt("hlt", 100);
    repeat (30) cyc();
    check("hlt_frozen_bus", {24'h0, bus8}, 0);
    check("hlt_still", {31'h0, halt8}, 1);

    // Load accepted while halted, dropped while running
    load8(4'hE, 8'h33);
    run8 = 1'b0;
    do_reset();
    check("rst_clears_halt", {31'h0, halt8}, 0);
    load8(4'h0, 8'h1E); load8(4'h1, 8'h30); load8(4'h2, 8'h1D);
    load8(4'h3, 8'h30); load8(4'h4, 8'hE0); load8(4'hD, 8'h44);
    q8.push_back(32'h33);
    q8.push_back(32'h44);
    run8 = 1'b1;
    cyc();
    load8(4'hD, 8'h99);
    wait_q8_halt("load", 100);
    run8 = 1'b0;

    // Single stepping from reset
    do_reset();
    check("rst_out_clear", {24'h0, out8}, 0);
    load8(4'h0, 8'h7A);
    step_pulse8();
    check("step1_pc", {24'h0, bus8}, 0);
    step_pulse8();
    check("step2_ram", {24'h0, bus8}, 32'h7A);
    step_pulse8();
    check("step3_opr", {24'h0, bus8}, 32'h0A);
    step_pulse8();
    check("step4_pc1", {24'h0, bus8}, 32'h01);
    repeat (5) cyc();
    check("step_idle", {24'h0, bus8}, 32'h01);

    // Reset mid-T4 of ADD, then restart from PC=0 with RAM intact
    do_reset();
    load8(4'h0, 8'h72); load8(4'h1, 8'h2F); load8(4'h2, 8'h30);
    load8(4'h3, 8'hE0); load8(4'hF, 8'h03);
    repeat (6) step_pulse8();
    check("add_t3_bus", {24'h0, bus8}, 32'h0F);
    step_pulse8();
    check("add_t4_bus", {24'h0, bus8}, 32'h03);
    reset_n = 1'b0;
    #1;
    check("async_rst_bus", {24'h0, bus8}, 0);
    check("async_rst_halt", {31'h0, halt8}, 0);
    cyc();
    reset_n = 1'b1;
    repeat (3) cyc();
    q8.push_back(32'h05);
    run8 = 1'b1;
    wait_q8_halt("restart", 100);
    check("restart_out", {24'h0, out8}, 32'h05);
    run8 = 1'b0;

    // DATA_W=12, ADDR_W=6, CLK_DIV=3: PC wraps 63 -> 0
    for (int i = 0; i < 64; i++) load12(6'(i), 12'hF00);
    load12(6'd0, 12'h72A); load12(6'd1, 12'h300); load12(6'd2, 12'h715);
    load12(6'd3, 12'h43C); load12(6'd63, 12'h300);
    q12.push_back(32'h02A);
    q12.push_back(32'h015);
    q12.push_back(32'h02A);
    t12.delete();
    c0 = cyc_cnt;
    run12 = 1'b1;
    for (int i = 0; i < 400 && q12.size() > 0; i++) cyc();
    run12 = 1'b0;
    check("wrap_pending", q12.size(), 0);
    check("wrap_pulses", t12.size(), 3);
    if (t12.size() == 3) begin
      check("wrap_first", t12[0] - c0, 18);
      check("wrap_gap1", t12[1] - t12[0], 54);
      check("wrap_gap2", t12[2] - t12[1], 18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
